// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one req/ack memory port between instruction fetch and
// data access, with a bounded data-priority streak and fetch flush support.
module mem_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  output logic              if_stall_o,
  input  logic              flush_i,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              busy_o
);

  localparam int unsigned STREAK_W = $clog2(MAX_DM_STREAK + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_BUSY = 3'd1,
    DM_BUSY = 3'd2,
    IF_RESP = 3'd3,
    DM_RESP = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                cancel_q, cancel_d;
  logic                mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_d, dm_rdata_d;
  logic                if_resp_q, if_resp_d;
  logic                dm_ready_d;
  logic                busy_d;
  logic                streak_max;

  assign streak_max = (streak_q == STREAK_W'(MAX_DM_STREAK));

  // A flush landing in the response cycle still hides the completion pulse.
  assign if_ready_o = if_resp_q & ~flush_i;
  assign if_stall_o = if_req_i & ~if_ready_o;
  assign dm_stall_o = dm_req_i & ~dm_ready_o;

  // Next-state, grant and capture logic.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    cancel_d    = cancel_q;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    if_rdata_d  = if_rdata_o;
    dm_rdata_d  = dm_rdata_o;
    if_resp_d   = 1'b0;
    dm_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (dm_req_i && !(if_req_i && streak_max)) begin
          state_d     = DM_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          if (if_req_i) streak_d = streak_q + STREAK_W'(1);
        end else if (if_req_i) begin
          state_d    = IF_BUSY;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i;
          streak_d   = '0;
        end
      end
      IF_BUSY: begin
        if (flush_i) cancel_d = 1'b1;
        if (mem_ack_i) begin
          if_rdata_d = mem_rdata_i;
          mem_req_d  = 1'b0;
          state_d    = IF_RESP;
          if_resp_d  = ~(cancel_q | flush_i);
        end
      end
      DM_BUSY: begin
        if (mem_ack_i) begin
          if (!mem_we_o) dm_rdata_d = mem_rdata_i;
          mem_req_d  = 1'b0;
          state_d    = DM_RESP;
          dm_ready_d = 1'b1;
        end
      end
      IF_RESP: begin
        state_d  = IDLE;
        cancel_d = 1'b0;
      end
      DM_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      cancel_q    <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      if_resp_q   <= 1'b0;
      dm_ready_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      cancel_q    <= cancel_d;
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      if_rdata_o  <= if_rdata_d;
      dm_rdata_o  <= dm_rdata_d;
      if_resp_q   <= if_resp_d;
      dm_ready_o  <= dm_ready_d;
      busy_o      <= busy_d;
    end
  end

endmodule
